cpu_bus_arbiter: RTL and testbench
==================================

Name: cpu_bus_arbiter

Overview:
Parametrised round-robin arbiter that replaces the wired-OR aggregation of CpuCell memory requests in front of DispatcherOfCpus.
- Exactly one of CPU_QUANTITY requesters owns the downstream bus at a time, so bus contents never depend on other requesters driving zeros.
- Uses a four-phase q/dn handshake per requester.
- Adds per-transaction timeout recovery and halt gating.

Parameters:
CPU_QUANTITY, 4, number of requesters (>=2)
ADDR_SIZE, 32, address width
DATA_SIZE, 32, data width
TIMEOUT_CYCLES, 255, max cycles waiting for downstream dn; 0 disables timeout
IDX_W, 2, width of requester index; must be >= ceil(log2(CPU_QUANTITY))

Ports:
clk  in  1  clock, all logic on rising edge
rst_in  in  1  synchronous reset, active-high
req_read_q  in  CPU_QUANTITY  per-requester read request
req_write_q  in  CPU_QUANTITY  per-requester write request
req_addr  in  CPU_QUANTITY*ADDR_SIZE  flattened addresses; requester i at [i*ADDR_SIZE +: ADDR_SIZE]
req_data  in  CPU_QUANTITY*DATA_SIZE  flattened write data, same packing
req_read_dn  out  CPU_QUANTITY  per-requester read done, one-cycle pulse
req_write_dn  out  CPU_QUANTITY  per-requester write done, one-cycle pulse
req_data_out  out  DATA_SIZE  read data; valid only in the cycle a req_read_dn bit is high
grant  out  CPU_QUANTITY  one-hot current owner; zero when idle
bus_busy  out  1  high whenever grant != 0
addr_out  out  ADDR_SIZE  downstream address (registered)
data_out  out  DATA_SIZE  downstream write data (registered)
read_q  out  1  downstream read request
write_q  out  1  downstream write request
data_in  in  DATA_SIZE  downstream read data
read_dn  in  1  downstream read done
write_dn  in  1  downstream write done
rw_halt_in  in  1  halt: blocks new grants and freezes timeout counter
timeout_err  out  1  one-cycle pulse on timeout
timeout_idx  out  IDX_W  index of the timed-out requester; held until the next timeout

Behaviour:
- Reset (rst_in high at a clock edge):
  - Every output goes to 0.
  - State goes to IDLE.
  - Round-robin pointer goes to CPU_QUANTITY-1, so requester 0 wins first.
  - Reset mid-transaction aborts the transaction without any dn pulse.
- States: IDLE, WAIT_DN, RELEASE.
- IDLE:
  - A requester is active if read_q|write_q is set for it.
  - If rw_halt_in is low and any requester is active, choose the first active index scanning from pointer+1 with wrap modulo CPU_QUANTITY.
  - On the next edge: set grant one-hot, register addr_out and data_out from the winner, set the pointer to the winner, go to WAIT_DN.
  - If the winner asserts both q bits, only write_q is raised. Its read is served as a new arbitration after RELEASE, if read_q is still high.
  - Latency: request sampled at cycle 0 -> grant and read_q/write_q high at cycle 1.
- WAIT_DN:
  - addr_out, data_out, read_q/write_q and grant hold stable.
  - Only the dn matching the active op completes it; the other dn input is ignored.
  - On the matching dn at cycle k, at cycle k+1:
    - the winner's req_*_dn bit pulses for one cycle;
    - for reads, req_data_out = data_in captured at cycle k;
    - read_q/write_q drop;
    - state goes to RELEASE.
  - Timeout counter starts at 0 on entry and increments each cycle while rw_halt_in is low.
  - When the counter reaches TIMEOUT_CYCLES (nonzero) without dn:
    - drop q;
    - pulse req_*_dn with req_data_out = 0;
    - pulse timeout_err and load timeout_idx;
    - go to RELEASE.
  - If dn and timeout occur in the same cycle, dn wins and timeout_err stays 0.
- RELEASE:
  - Hold grant until the winner deasserts both its q bits.
  - The edge after observing deassertion clears grant and returns to IDLE.
  - Earliest next grant is one cycle later, so grant is never back-to-back.
- A grant is never revoked except by reset or timeout completion.
- Requests from non-winners are ignored and cause no pulses.
- req_data_out is 0 in every cycle with no read_dn pulse.

Test Plan:
1. Single read: requester 2 raises read_q, addr 0x100; downstream gives read_dn + data_in=0xDEADBEEF at cycle 4.
   -> grant=0100 and read_q=1 at cycle 1; addr_out=0x100; req_read_dn[2] pulses at cycle 5 with req_data_out=0xDEADBEEF.
2. Round-robin: requesters 0, 1, 3 hold write_q continuously; each transaction is acked and its q is dropped, then re-raised.
   -> grant order 0,1,3,0,1,3; no requester is granted twice consecutively.
3. Simultaneous read+write: requester 1 asserts both q bits.
   -> write served first (write_q=1, read_q=0); after release, read served as a separate grant.
4. Timeout with TIMEOUT_CYCLES=8: requester 3 reads with no read_dn.
   -> 8 counted cycles after grant: timeout_err pulse, timeout_idx=3, req_read_dn[3] pulse with data 0.
   -> Repeat with rw_halt_in high for 5 of those cycles: timeout delayed by exactly 5 cycles.
5. Halt gating: rw_halt_in high while requester 0 raises read_q.
   -> grant stays 0; grant appears one cycle after rw_halt_in falls.
6. Reset mid-transaction: rst_in pulsed during WAIT_DN.
   -> all outputs 0 next cycle, no dn pulse, next arbitration starts at requester 0.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter giving exactly one CPU requester ownership of the downstream bus,
// with per-transaction timeout recovery and halt gating of new grants.
module cpu_bus_arbiter #(
    parameter int          CPU_QUANTITY   = 4,
    parameter int          ADDR_SIZE      = 32,
    parameter int          DATA_SIZE      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int          IDX_W          = 2
) (
    input  logic                              clk,
    input  logic                              rst_in,
    input  logic [CPU_QUANTITY-1:0]           req_read_q,
    input  logic [CPU_QUANTITY-1:0]           req_write_q,
    input  logic [CPU_QUANTITY*ADDR_SIZE-1:0] req_addr,
    input  logic [CPU_QUANTITY*DATA_SIZE-1:0] req_data,
    output logic [CPU_QUANTITY-1:0]           req_read_dn,
    output logic [CPU_QUANTITY-1:0]           req_write_dn,
    output logic [DATA_SIZE-1:0]              req_data_out,
    output logic [CPU_QUANTITY-1:0]           grant,
    output logic                              bus_busy,
    output logic [ADDR_SIZE-1:0]              addr_out,
    output logic [DATA_SIZE-1:0]              data_out,
    output logic                              read_q,
    output logic                              write_q,
    input  logic [DATA_SIZE-1:0]              data_in,
    input  logic                              read_dn,
    input  logic                              write_dn,
    input  logic                              rw_halt_in,
    output logic                              timeout_err,
    output logic [IDX_W-1:0]                  timeout_idx,
    output logic [1:0]                        dbg_state
);

    // Handshake: a requester raises q and holds it; completion is a one-cycle dn pulse;
    // the requester then drops all q bits, and only after that is the grant released.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_DN = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W:0] TO_VAL = (CNT_W + 1)'(TIMEOUT_CYCLES);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        win_q, win_d;
    logic [CPU_QUANTITY-1:0] grant_q, grant_d;
    logic [ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [DATA_SIZE-1:0]    data_q, data_d;
    logic                    rdq_q, rdq_d;
    logic                    wrq_q, wrq_d;
    logic                    opwr_q, opwr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CPU_QUANTITY-1:0] rd_dn_q, rd_dn_d;
    logic [CPU_QUANTITY-1:0] wr_dn_q, wr_dn_d;
    logic [DATA_SIZE-1:0]    rdata_q, rdata_d;
    logic                    terr_q, terr_d;
    logic [IDX_W-1:0]        tidx_q, tidx_d;

    logic [CPU_QUANTITY-1:0] active;
    logic                    found;
    logic [IDX_W-1:0]        pick;
    logic                    done_hit;
    logic [CNT_W:0]          cnt_inc;

    assign active   = req_read_q | req_write_q;
    assign done_hit = opwr_q ? write_dn : read_dn;
    assign cnt_inc  = {1'b0, cnt_q} + 1'b1;

    // Scan starts just after the last winner so the previous owner is considered last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= CPU_QUANTITY; k++) begin
            if (!found && active[(int'(ptr_q) + k) % CPU_QUANTITY]) begin
                found = 1'b1;
                pick  = IDX_W'((int'(ptr_q) + k) % CPU_QUANTITY);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdq_d   = rdq_q;
        wrq_d   = wrq_q;
        opwr_d  = opwr_q;
        cnt_d   = cnt_q;
        rd_dn_d = '0;
        wr_dn_d = '0;
        rdata_d = '0;
        terr_d  = 1'b0;
        tidx_d  = tidx_q;

        case (state_q)
            S_IDLE: begin
                if (!rw_halt_in && found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    win_d         = pick;
                    ptr_d         = pick;
                    addr_d        = req_addr[int'(pick)*ADDR_SIZE +: ADDR_SIZE];
                    data_d        = req_data[int'(pick)*DATA_SIZE +: DATA_SIZE];
                    // A winner asking for both ops gets its write first.
                    opwr_d        = req_write_q[pick];
                    wrq_d         = req_write_q[pick];
                    rdq_d         = !req_write_q[pick];
                    cnt_d         = '0;
                    state_d       = S_WAIT_DN;
                end
            end
            S_WAIT_DN: begin
                if (done_hit) begin
                    rdq_d   = 1'b0;
                    wrq_d   = 1'b0;
                    state_d = S_RELEASE;
                    if (opwr_q) begin
                        wr_dn_d = grant_q;
                    end else begin
                        rd_dn_d = grant_q;
                        rdata_d = data_in;
                    end
                end else if (!rw_halt_in) begin
                    if (TIMEOUT_CYCLES != 0 && cnt_inc == TO_VAL) begin
                        rdq_d   = 1'b0;
                        wrq_d   = 1'b0;
                        terr_d  = 1'b1;
                        tidx_d  = win_q;
                        state_d = S_RELEASE;
                        if (opwr_q) begin
                            wr_dn_d = grant_q;
                        end else begin
                            rd_dn_d = grant_q;
                        end
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            S_RELEASE: begin
                if (!active[win_q]) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                rdq_d   = 1'b0;
                wrq_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            ptr_q   <= IDX_W'(CPU_QUANTITY - 1);
            win_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdq_q   <= 1'b0;
            wrq_q   <= 1'b0;
            opwr_q  <= 1'b0;
            cnt_q   <= '0;
            rd_dn_q <= '0;
            wr_dn_q <= '0;
            rdata_q <= '0;
            terr_q  <= 1'b0;
            tidx_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdq_q   <= rdq_d;
            wrq_q   <= wrq_d;
            opwr_q  <= opwr_d;
            cnt_q   <= cnt_d;
            rd_dn_q <= rd_dn_d;
            wr_dn_q <= wr_dn_d;
            rdata_q <= rdata_d;
            terr_q  <= terr_d;
            tidx_q  <= tidx_d;
        end
    end

    assign grant        = grant_q;
    assign bus_busy     = |grant_q;
    assign addr_out     = addr_q;
    assign data_out     = data_q;
    assign read_q       = rdq_q;
    assign write_q      = wrq_q;
    assign req_read_dn  = rd_dn_q;
    assign req_write_dn = wr_dn_q;
    assign req_data_out = rdata_q;
    assign timeout_err  = terr_q;
    assign timeout_idx  = tidx_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed cycle-exact scenarios, then randomized batches
// checked by a scoreboard fed from a round-robin reference model.
module tb_cpu_bus_arbiter;

    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IW    = 2;
    localparam int TO    = 8;
    localparam int EXP_W = 1 + IW + AW + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_in      = 1'b0;
    logic [N-1:0]    req_read_q  = '0;
    logic [N-1:0]    req_write_q = '0;
    logic [N*AW-1:0] req_addr    = '0;
    logic [N*DW-1:0] req_data    = '0;
    logic            rw_halt_in  = 1'b0;

    logic            m_read_dn = 1'b0, m_write_dn = 1'b0;
    logic [DW-1:0]   m_data    = '0;
    logic            r_read_dn = 1'b0, r_write_dn = 1'b0;
    logic [DW-1:0]   r_data    = '0;
    logic            resp_en   = 1'b0;
    logic            mon_en    = 1'b0;

    wire             read_dn  = resp_en ? r_read_dn  : m_read_dn;
    wire             write_dn = resp_en ? r_write_dn : m_write_dn;
    wire  [DW-1:0]   data_in  = resp_en ? r_data     : m_data;

    wire  [N-1:0]    req_read_dn, req_write_dn, grant;
    wire  [DW-1:0]   req_data_out, data_out;
    wire  [AW-1:0]   addr_out;
    wire             bus_busy, read_q, write_q, timeout_err;
    wire  [IW-1:0]   timeout_idx;
    wire  [1:0]      dbg_state;

    cpu_bus_arbiter #(
        .CPU_QUANTITY(N), .ADDR_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(TO), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst_in(rst_in),
        .req_read_q(req_read_q), .req_write_q(req_write_q),
        .req_addr(req_addr), .req_data(req_data),
        .req_read_dn(req_read_dn), .req_write_dn(req_write_dn), .req_data_out(req_data_out),
        .grant(grant), .bus_busy(bus_busy),
        .addr_out(addr_out), .data_out(data_out),
        .read_q(read_q), .write_q(write_q),
        .data_in(data_in), .read_dn(read_dn), .write_dn(write_dn),
        .rw_halt_in(rw_halt_in),
        .timeout_err(timeout_err), .timeout_idx(timeout_idx),
        .dbg_state(dbg_state)
    );

    // Scoreboard state
    logic [EXP_W-1:0] exp_q[$];
    logic [DW-1:0]    rd_data_q[$];
    int               obs_order[$];
    int               checks   = 0;
    int               failures = 0;
    int               m_ptr    = N - 1;

    function automatic logic [N-1:0] oh(input int i);
        oh = N'(1) << i;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_bus_busy"}, bus_busy, 0);
        check({tag, "_addr_out"}, addr_out, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_read_q"}, read_q, 0);
        check({tag, "_write_q"}, write_q, 0);
        check({tag, "_req_read_dn"}, req_read_dn, 0);
        check({tag, "_req_write_dn"}, req_write_dn, 0);
        check({tag, "_req_data_out"}, req_data_out, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_timeout_idx"}, timeout_idx, 0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        check_zero("reset");
        rst_in = 1'b0;
        m_ptr  = N - 1;
    endtask

    // Random downstream responder: acks after 0..4 cycles, sometimes pulses the wrong dn first.
    initial begin
        int  wait_cnt;
        bit  acked;
        wait_cnt = 0;
        acked    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            r_read_dn  = 1'b0;
            r_write_dn = 1'b0;
            r_data     = $urandom;
            if (!resp_en || !(read_q || write_q)) begin
                acked    = 1'b0;
                wait_cnt = $urandom_range(0, 4);
            end else if (!acked) begin
                if (wait_cnt == 0) begin
                    if (write_q) begin
                        r_write_dn = 1'b1;
                    end else begin
                        r_read_dn = 1'b1;
                        rd_data_q.push_back(r_data);
                    end
                    acked = 1'b1;
                end else begin
                    wait_cnt--;
                    if ($urandom_range(0, 3) == 0) begin
                        if (write_q) r_read_dn = 1'b1;
                        else         r_write_dn = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: pops expected bus transactions and checks the completions back to requesters.
    initial begin
        logic             prev_qa;
        logic [EXP_W-1:0] cur_e;
        logic             cur_wr;
        int               cur_idx;
        prev_qa = 1'b0;
        cur_e   = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if ((read_q || write_q) && !prev_qa) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_grant: got grant=%0h with no expected transaction", grant);
                    end else begin
                        cur_e   = exp_q.pop_front();
                        cur_wr  = cur_e[EXP_W-1];
                        cur_idx = int'(cur_e[AW+DW +: IW]);
                        check("sb_grant", grant, oh(cur_idx));
                        check("sb_write_q", write_q, cur_wr);
                        check("sb_read_q", read_q, !cur_wr);
                        check("sb_addr_out", addr_out, cur_e[DW +: AW]);
                        check("sb_data_out", data_out, cur_e[DW-1:0]);
                        obs_order.push_back(cur_idx);
                    end
                end
                prev_qa = read_q || write_q;
                cur_wr  = cur_e[EXP_W-1];
                cur_idx = int'(cur_e[AW+DW +: IW]);
                if ((req_read_dn | req_write_dn) != 0) begin
                    check("sb_req_write_dn", req_write_dn, cur_wr ? oh(cur_idx) : '0);
                    check("sb_req_read_dn", req_read_dn, cur_wr ? '0 : oh(cur_idx));
                    if (!cur_wr) begin
                        if (rd_data_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL sb_rdata: read done with no downstream read data recorded");
                        end else begin
                            check("sb_req_data_out", req_data_out, rd_data_q.pop_front());
                        end
                    end
                end else begin
                    check("sb_req_data_out_idle", req_data_out, 0);
                end
                check("sb_timeout_err", timeout_err, 0);
                check("sb_bus_busy", bus_busy, grant != 0);
            end
        end
    end

    // Raise a set of requests at once and serve them; the model predicts the service order.
    task automatic run_batch(input logic [N-1:0] rd, input logic [N-1:0] wr);
        logic [N-1:0] prd, pwr, need, done, rer;
        int           pick, cyc;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = $urandom;
            req_data[i*DW +: DW] = $urandom;
        end
        prd = rd;
        pwr = wr;
        while ((prd | pwr) != 0) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                int j = (m_ptr + k) % N;
                if (pick < 0 && (prd[j] || pwr[j])) pick = j;
            end
            if (pwr[pick]) begin
                exp_q.push_back({1'b1, IW'(pick), req_addr[pick*AW +: AW], req_data[pick*DW +: DW]});
                pwr[pick] = 1'b0;
            end else begin
                exp_q.push_back({1'b0, IW'(pick), req_addr[pick*AW +: AW], req_data[pick*DW +: DW]});
                prd[pick] = 1'b0;
            end
            m_ptr = pick;
        end
        req_read_q  = rd;
        req_write_q = wr;
        need = rd | wr;
        done = '0;
        rer  = '0;
        cyc  = 0;
        while (!(done == need && grant == 0)) begin
            tick();
            cyc++;
            rw_halt_in = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) begin
                if (req_write_dn[i]) begin
                    req_write_q[i] = 1'b0;
                    req_read_q[i]  = 1'b0;
                    if (rd[i]) rer[i] = 1'b1;
                    else       done[i] = 1'b1;
                end else if (req_read_dn[i]) begin
                    req_write_q[i] = 1'b0;
                    req_read_q[i]  = 1'b0;
                    done[i]        = 1'b1;
                end else if (rer[i] && !grant[i]) begin
                    req_read_q[i] = 1'b1;
                    rer[i]        = 1'b0;
                end
            end
            if (cyc > 400) begin
                checks++;
                failures++;
                $display("FAIL batch_budget: done=%0h need=%0h grant=%0h", done, need, grant);
                break;
            end
        end
        rw_halt_in  = 1'b0;
        req_read_q  = '0;
        req_write_q = '0;
    endtask

    initial begin
        int rr_exp[6];
        rr_exp = '{0, 1, 3, 0, 1, 3};
        tick();
        do_reset();

        // Single read from requester 2, downstream done at cycle 4
        req_read_q[2] = 1'b1;
        req_addr[2*AW +: AW] = 32'h100;
        tick();
        check("t1_grant", grant, 4'b0100);
        check("t1_read_q", read_q, 1);
        check("t1_write_q", write_q, 0);
        check("t1_addr_out", addr_out, 32'h100);
        tick();
        tick();
        check("t1_no_dn_early", req_read_dn, 0);
        tick();
        m_read_dn = 1'b1;
        m_data    = 32'hDEADBEEF;
        tick();
        m_read_dn = 1'b0;
        m_data    = 32'h0BADF00D;
        check("t1_req_read_dn", req_read_dn, 4'b0100);
        check("t1_req_data_out", req_data_out, 32'hDEADBEEF);
        check("t1_read_q_drop", read_q, 0);
        check("t1_grant_held", grant, 4'b0100);
        req_read_q[2] = 1'b0;
        tick();
        check("t1_grant_clear", grant, 0);
        check("t1_dn_one_cycle", req_read_dn, 0);
        check("t1_data_out_zero", req_data_out, 0);

        // Requester 1 asks for read and write together
        req_read_q[1]  = 1'b1;
        req_write_q[1] = 1'b1;
        req_addr[1*AW +: AW] = 32'h200;
        req_data[1*DW +: DW] = 32'hCAFE0001;
        tick();
        check("t3_grant_w", grant, 4'b0010);
        check("t3_write_q", write_q, 1);
        check("t3_read_q", read_q, 0);
        check("t3_data_out", data_out, 32'hCAFE0001);
        m_read_dn = 1'b1;
        tick();
        m_read_dn = 1'b0;
        check("t3_wrong_dn_ignored", req_read_dn | req_write_dn, 0);
        check("t3_write_q_hold", write_q, 1);
        m_write_dn = 1'b1;
        tick();
        m_write_dn = 1'b0;
        check("t3_req_write_dn", req_write_dn, 4'b0010);
        check("t3_no_read_dn", req_read_dn, 0);
        req_read_q[1]  = 1'b0;
        req_write_q[1] = 1'b0;
        tick();
        check("t3_release", grant, 0);
        req_read_q[1] = 1'b1;
        tick();
        check("t3_grant_r", grant, 4'b0010);
        check("t3_read_q2", read_q, 1);
        check("t3_write_q2", write_q, 0);
        m_read_dn = 1'b1;
        m_data    = 32'h12345678;
        tick();
        m_read_dn = 1'b0;
        check("t3_req_read_dn", req_read_dn, 4'b0010);
        check("t3_req_data_out", req_data_out, 32'h12345678);
        req_read_q[1] = 1'b0;
        tick();

        // Timeout: requester 3 reads, nobody answers
        m_data = 32'hFFFFFFFF;
        req_read_q[3] = 1'b1;
        req_addr[3*AW +: AW] = 32'h300;
        tick();
        check("t4_grant", grant, 4'b1000);
        for (int c = 2; c <= 8; c++) tick();
        check("t4_no_to_c8", timeout_err, 0);
        tick();
        check("t4_timeout_err", timeout_err, 1);
        check("t4_timeout_idx", timeout_idx, 3);
        check("t4_req_read_dn", req_read_dn, 4'b1000);
        check("t4_data_zero", req_data_out, 0);
        check("t4_read_q_drop", read_q, 0);
        tick();
        check("t4_err_pulse", timeout_err, 0);
        check("t4_idx_held", timeout_idx, 3);
        check("t4_grant_held", grant, 4'b1000);
        req_read_q[3] = 1'b0;
        tick();
        check("t4_release", grant, 0);

        // Timeout with halt high for 5 of the counted cycles
        req_read_q[3] = 1'b1;
        tick();
        check("t4h_grant", grant, 4'b1000);
        tick();
        tick();
        rw_halt_in = 1'b1;
        for (int c = 4; c <= 8; c++) tick();
        rw_halt_in = 1'b0;
        for (int c = 9; c <= 13; c++) tick();
        check("t4h_no_to_c13", timeout_err, 0);
        tick();
        check("t4h_timeout_err", timeout_err, 1);
        check("t4h_req_read_dn", req_read_dn, 4'b1000);
        req_read_q[3] = 1'b0;
        tick();
        check("t4h_release", grant, 0);

        // Done and timeout in the same cycle: done wins
        req_read_q[3] = 1'b1;
        tick();
        for (int c = 2; c <= 8; c++) tick();
        m_read_dn = 1'b1;
        m_data    = 32'hA5A5A5A5;
        tick();
        m_read_dn = 1'b0;
        check("t4d_no_timeout", timeout_err, 0);
        check("t4d_req_read_dn", req_read_dn, 4'b1000);
        check("t4d_data", req_data_out, 32'hA5A5A5A5);
        req_read_q[3] = 1'b0;
        tick();

        // Halt gating of a new grant
        rw_halt_in    = 1'b1;
        req_read_q[0] = 1'b1;
        req_addr[0*AW +: AW] = 32'h44;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("t5_halted_grant", grant, 0);
        end
        rw_halt_in = 1'b0;
        tick();
        check("t5_grant_after_halt", grant, 4'b0001);
        check("t5_read_q", read_q, 1);
        m_read_dn = 1'b1;
        m_data    = 32'h55;
        tick();
        m_read_dn = 1'b0;
        check("t5_req_read_dn", req_read_dn, 4'b0001);
        req_read_q[0] = 1'b0;
        tick();

        // Reset in the middle of a write
        req_write_q[2] = 1'b1;
        req_addr[2*AW +: AW] = 32'h400;
        tick();
        check("t6_grant", grant, 4'b0100);
        rst_in     = 1'b1;
        m_write_dn = 1'b1;
        tick();
        rst_in     = 1'b0;
        m_write_dn = 1'b0;
        check_zero("t6_midreset");
        req_write_q[0] = 1'b1;
        req_write_q[3] = 1'b1;
        tick();
        check("t6_restart_at_0", grant, 4'b0001);
        check("t6_no_late_dn", req_write_dn, 0);
        m_write_dn = 1'b1;
        tick();
        m_write_dn = 1'b0;
        check("t6_req_write_dn", req_write_dn, 4'b0001);
        req_write_q = '0;
        tick();
        tick();

        // Scoreboard phase: round-robin order, then random batches
        do_reset();
        resp_en = 1'b1;
        mon_en  = 1'b1;
        run_batch(4'b0000, 4'b1011);
        run_batch(4'b0000, 4'b1011);
        if (obs_order.size() < 6) begin
            checks++;
            failures++;
            $display("FAIL rr_order_len: got=%0d expected=6", obs_order.size());
        end else begin
            for (int i = 0; i < 6; i++) check("rr_order", obs_order[i], rr_exp[i]);
        end
        obs_order.delete();
        for (int b = 0; b < 30; b++) begin
            logic [N-1:0] rd, wr;
            rd = N'($urandom_range(0, 15));
            wr = N'($urandom_range(0, 15));
            if ((rd | wr) == 0) wr = oh($urandom_range(0, N - 1));
            run_batch(rd, wr);
        end
        tick();
        tick();
        mon_en = 1'b0;
        check("exp_q_drained", exp_q.size(), 0);
        check("rdata_drained", rd_data_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
